// File: rtl/gpio_apb_irq.sv
// APB GPIO peripheral: output, input and 7-segment registers plus per-pin
// edge-detect interrupts that are merged onto one registered level irq line.

module gpio_apb_irq_pin #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  input  logic en,
  input  logic pol,
  input  logic clr,
  output logic sync,
  output logic pend
);
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   prev;
  logic                   set;

  assign sync = sync_pipe[SYNC_STAGES-1];
  assign set  = en & (pol ? (sync & ~prev) : (~sync & prev));

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_pipe <= '0;
      prev      <= 1'b0;
      pend      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], pin};
      prev      <= sync;
      // A new edge takes priority over a W1C landing in the same cycle
      pend      <= set | (pend & ~clr);
    end
  end
endmodule

module gpio_apb_irq #(
  parameter int NUM_GPIO    = 16,
  parameter int NUM_SEG     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [31:0]           in_paddr,
  input  logic                  in_psel,
  input  logic                  in_penable,
  input  logic [2:0]            in_pprot,
  input  logic                  in_pwrite,
  input  logic [31:0]           in_pwdata,
  input  logic [3:0]            in_pstrb,
  output logic                  in_pready,
  output logic [31:0]           in_prdata,
  output logic                  in_pslverr,
  output logic [NUM_GPIO-1:0]   gpio_out,
  input  logic [NUM_GPIO-1:0]   gpio_in,
  output logic [8*NUM_SEG-1:0]  gpio_seg,
  output logic                  irq
);
  typedef enum logic [2:0] {
    A_OUT, A_IN, A_SEG_LO, A_SEG_HI, A_IRQ_EN, A_IRQ_POL, A_IRQ_PEND, A_NONE
  } addr_e;

  logic                       access, wr;
  addr_e                      addr;
  logic [NUM_GPIO-1:0]        wmask, wdata_g;
  logic [NUM_GPIO-1:0]        out_q, irq_en, irq_pol, irq_pend, pend_clr, sync_in;
  logic [NUM_SEG-1:0][7:0]    seg_q;
  logic [63:0]                seg_all;
  logic                       unused_ok;

  assign access    = in_psel & in_penable;
  assign wr        = access & in_pwrite;
  assign addr      = addr_e'(in_paddr[4:2]);
  assign wdata_g   = in_pwdata[NUM_GPIO-1:0];
  assign in_pready = 1'b1;
  assign gpio_out  = out_q;
  assign gpio_seg  = seg_q;
  assign seg_all   = 64'(seg_q);
  assign unused_ok = ^{in_paddr[31:5], in_paddr[1:0], in_pprot, in_pwdata, in_pstrb};

  always_comb begin
    wmask = '0;
    for (int i = 0; i < NUM_GPIO; i++) wmask[i] = in_pstrb[i/8];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q   <= '0;
      irq_en  <= '0;
      irq_pol <= '0;
    end else if (wr) begin
      if (addr == A_OUT)     out_q   <= (out_q   & ~wmask) | (wdata_g & wmask);
      if (addr == A_IRQ_EN)  irq_en  <= (irq_en  & ~wmask) | (wdata_g & wmask);
      if (addr == A_IRQ_POL) irq_pol <= (irq_pol & ~wmask) | (wdata_g & wmask);
    end
  end

  // Digits 0..3 live in SEG_LO, 4..7 in SEG_HI; byte lane = digit mod 4
  always_ff @(posedge clock) begin
    if (reset) seg_q <= '0;
    else if (wr) begin
      for (int d = 0; d < NUM_SEG; d++)
        if (((addr == A_SEG_LO && d < 4) || (addr == A_SEG_HI && d >= 4)) && in_pstrb[d%4])
          seg_q[d] <= in_pwdata[8*(d%4)+:8];
    end
  end

  assign pend_clr = (wr && addr == A_IRQ_PEND) ? (wmask & wdata_g) : '0;

  for (genvar i = 0; i < NUM_GPIO; i++) begin : g_pin
    gpio_apb_irq_pin #(.SYNC_STAGES(SYNC_STAGES)) u_pin (
      .clock (clock),
      .reset (reset),
      .pin   (gpio_in[i]),
      .en    (irq_en[i]),
      .pol   (irq_pol[i]),
      .clr   (pend_clr[i]),
      .sync  (sync_in[i]),
      .pend  (irq_pend[i])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(irq_pend & irq_en);
  end

  always_comb begin
    in_prdata = '0;
    if (access) begin
      case (addr)
        A_OUT:      in_prdata = 32'(out_q);
        A_IN:       in_prdata = 32'(sync_in);
        A_SEG_LO:   in_prdata = seg_all[31:0];
        A_SEG_HI:   in_prdata = seg_all[63:32];
        A_IRQ_EN:   in_prdata = 32'(irq_en);
        A_IRQ_POL:  in_prdata = 32'(irq_pol);
        A_IRQ_PEND: in_prdata = 32'(irq_pend);
        default:    in_prdata = '0;
      endcase
    end
  end

  assign in_pslverr = access & ((addr == A_NONE) | (addr == A_IN & in_pwrite));
endmodule

// File: tb/tb_gpio_apb_irq.sv
// Randomized APB/pin stimulus for gpio_apb_irq checked against a cycle-level
// behavioural model of the register map and edge interrupts.

module tb_gpio_apb_irq;
  localparam int G    = 16;
  localparam int SEGN = 6;
  localparam int S    = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [31:0]     in_paddr = '0;
  logic            in_psel = 1'b0, in_penable = 1'b0, in_pwrite = 1'b0;
  logic [2:0]      in_pprot = '0;
  logic [31:0]     in_pwdata = '0;
  logic [3:0]      in_pstrb = '0;
  logic            in_pready, in_pslverr, irq;
  logic [31:0]     in_prdata;
  logic [G-1:0]    gpio_out;
  logic [G-1:0]    gpio_in = '0;
  logic [8*SEGN-1:0] gpio_seg;

  gpio_apb_irq #(.NUM_GPIO(G), .NUM_SEG(SEGN), .SYNC_STAGES(S)) dut (
    .clock(clock), .reset(reset),
    .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable), .in_pprot(in_pprot),
    .in_pwrite(in_pwrite), .in_pwdata(in_pwdata), .in_pstrb(in_pstrb),
    .in_pready(in_pready), .in_prdata(in_prdata), .in_pslverr(in_pslverr),
    .gpio_out(gpio_out), .gpio_in(gpio_in), .gpio_seg(gpio_seg), .irq(irq)
  );

  always #5 clock = ~clock;

  int n_tests = 0, n_fail = 0;

  // Reference state: registers as the programmer sees them, pin history newest-first
  logic [G-1:0] m_out, m_en, m_pol, m_pend;
  logic [7:0]   m_seg [8];
  logic         m_irq;
  logic [G-1:0] hist [0:S];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] seg_exp();
    logic [63:0] r = '0;
    for (int d = 0; d < SEGN; d++) r[8*d+:8] = m_seg[d];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    logic [31:0] r = '0;
    case (a)
      3'd0: r = 32'(m_out);
      3'd1: r = 32'(hist[S-1]);
      3'd2: for (int b = 0; b < 4; b++) if (b < SEGN) r[8*b+:8] = m_seg[b];
      3'd3: for (int b = 0; b < 4; b++) if (b + 4 < SEGN) r[8*b+:8] = m_seg[b+4];
      3'd4: r = 32'(m_en);
      3'd5: r = 32'(m_pol);
      3'd6: r = 32'(m_pend);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Advance the model across one clock edge using the inputs currently driven
  task automatic model_step();
    logic [G-1:0] wm, sy, pv, edg, clr;
    logic acc;
    logic [2:0] a;
    if (reset) begin
      m_out = '0; m_en = '0; m_pol = '0; m_pend = '0; m_irq = 1'b0;
      for (int d = 0; d < 8; d++) m_seg[d] = '0;
      for (int k = 0; k <= S; k++) hist[k] = '0;
    end else begin
      acc = in_psel && in_penable;
      a   = in_paddr[4:2];
      for (int i = 0; i < G; i++) wm[i] = in_pstrb[i/8];
      sy  = hist[S-1];
      pv  = hist[S];
      edg = (m_pol & sy & ~pv) | (~m_pol & ~sy & pv);
      clr = (acc && in_pwrite && a == 3'd6) ? (in_pwdata[G-1:0] & wm) : '0;
      m_irq  = |(m_pend & m_en);
      m_pend = (m_pend & ~clr) | (edg & m_en);
      if (acc && in_pwrite) begin
        case (a)
          3'd0: m_out = (m_out & ~wm) | (in_pwdata[G-1:0] & wm);
          3'd2: for (int b = 0; b < 4; b++) if (in_pstrb[b] && b < SEGN) m_seg[b] = in_pwdata[8*b+:8];
          3'd3: for (int b = 0; b < 4; b++) if (in_pstrb[b] && b + 4 < SEGN) m_seg[b+4] = in_pwdata[8*b+:8];
          3'd4: m_en  = (m_en  & ~wm) | (in_pwdata[G-1:0] & wm);
          3'd5: m_pol = (m_pol & ~wm) | (in_pwdata[G-1:0] & wm);
          default: ;
        endcase
      end
      for (int k = S; k >= 1; k--) hist[k] = hist[k-1];
      hist[0] = gpio_in;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    chk("gpio_out", 64'(gpio_out), 64'(m_out));
    chk("gpio_seg", 64'(gpio_seg), seg_exp());
    chk("irq", 64'(irq), 64'(m_irq));
    if (!(in_psel && in_penable)) begin
      chk("idle_prdata", 64'(in_prdata), 64'd0);
      chk("idle_pslverr", 64'(in_pslverr), 64'd0);
    end
  endtask

  task automatic setup(input logic [2:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    in_paddr   = $urandom;
    in_paddr[4:2] = a;
    in_pprot   = 3'($urandom);
    in_psel    = 1'b1;
    in_penable = 1'b0;
    in_pwrite  = w;
    in_pwdata  = d;
    in_pstrb   = s;
    tick();
    in_penable = 1'b1;
    #1;
  endtask

  task automatic apb_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    setup(a, 1'b1, d, s);
    chk("wr_pready", 64'(in_pready), 64'd1);
    chk($sformatf("wr%0d_pslverr", a), 64'(in_pslverr), 64'(a == 3'd7 || a == 3'd1));
    tick();
    in_psel = 1'b0; in_penable = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [31:0] d);
    setup(a, 1'b0, $urandom, 4'($urandom));
    d = in_prdata;
    chk($sformatf("rd%0d_data", a), 64'(in_prdata), 64'(exp_rd(a)));
    chk($sformatf("rd%0d_pslverr", a), 64'(in_pslverr), 64'(a == 3'd7));
    tick();
    in_psel = 1'b0; in_penable = 1'b0;
  endtask

  initial begin
    logic [31:0] d, d2;
    int k;
    // 1: reset, everything reads 0
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int a = 0; a < 7; a++) begin
      apb_read(3'(a), d);
      chk("t1_zero", 64'(d), 64'd0);
    end
    chk("t1_irq", 64'(irq), 64'd0);

    // 2: partial-strobe OUT write
    apb_write(3'd0, 32'hFFFF_FFFF, 4'b0001);
    chk("t2_gpio_out", 64'(gpio_out), 64'h00FF);
    apb_read(3'd0, d);
    chk("t2_read_out", 64'(d), 64'h0000_00FF);

    // 3: SEG_HI with only two digits implemented above 4
    apb_write(3'd3, 32'h1122_3344, 4'hF);
    chk("t3_seg45", 64'(gpio_seg[47:32]), 64'h3344);
    apb_read(3'd3, d);
    chk("t3_read_seghi", 64'(d), 64'h0000_3344);

    // 4: rising edge on pin 3
    apb_write(3'd4, 32'h8, 4'hF);
    apb_write(3'd5, 32'h8, 4'hF);
    gpio_in[3] = 1'b1;
    repeat (S + 1) tick();
    chk("t4_irq_early", 64'(irq), 64'd0);
    tick();
    chk("t4_irq_set", 64'(irq), 64'd1);
    apb_read(3'd6, d);
    chk("t4_pend", 64'(d), 64'h8);
    apb_write(3'd6, 32'h8, 4'hF);
    chk("t4_irq_hold", 64'(irq), 64'd1);
    tick();
    chk("t4_irq_drop", 64'(irq), 64'd0);

    // 5: falling edge on pin 5 coinciding with its W1C
    apb_write(3'd4, 32'h28, 4'hF);
    apb_write(3'd5, 32'h08, 4'hF);
    gpio_in[5] = 1'b1;
    repeat (4) tick();
    gpio_in[5] = 1'b0;
    tick();
    apb_write(3'd6, 32'h20, 4'hF);
    apb_read(3'd6, d);
    chk("t5_set_wins", 64'(d & 32'h20), 64'h20);
    gpio_in[7] = 1'b1;
    repeat (4) tick();
    gpio_in[7] = 1'b0;
    repeat (4) tick();
    apb_read(3'd6, d2);
    chk("t5_disabled", 64'(d2), 64'(d));

    // 6: error responses
    apb_write(3'd1, 32'hFFFF_FFFF, 4'hF);
    apb_write(3'd7, 32'hFFFF_FFFF, 4'hF);
    apb_read(3'd7, d);
    chk("t6_unmapped", 64'(d), 64'd0);
    for (int a = 0; a < 7; a++) apb_read(3'(a), d);

    // Random traffic, pin activity and occasional reset mid-transfer
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          k = $urandom_range(0, G - 1);
          gpio_in[k] = ~gpio_in[k];
          tick();
        end
        2, 3, 4: apb_write(3'($urandom_range(0, 7)), $urandom, 4'($urandom));
        5, 6, 7: apb_read(3'($urandom_range(0, 7)), d);
        8: tick();
        default: begin
          if ($urandom_range(0, 3) == 0) begin
            setup(3'($urandom_range(0, 7)), 1'b1, $urandom, 4'hF);
            reset = 1'b1;
            tick();
            reset = 1'b0;
            in_psel = 1'b0; in_penable = 1'b0;
            tick();
          end else tick();
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
